// File: rtl/serial_magnitude_compare_pkg.sv
// Shared definitions for the digit-serial magnitude comparator.
//   op_e    : result select carried with each request (A vs B)
//   state_e : controller states IDLE -> SCAN -> DONE -> IDLE
//   idx_width() : digit-index width, never narrower than one bit
//   op_result() : relation picked out of the gt/lt/eq flags by op
package serial_magnitude_compare_pkg;

    typedef enum logic [1:0] {
        OP_EQ = 2'b00,
        OP_GT = 2'b01,
        OP_LT = 2'b10,
        OP_GE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic int idx_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

    function automatic logic op_result(input op_e op, input logic gt, input logic lt,
                                       input logic eq);
        logic r;
        case (op)
            OP_EQ:   r = eq;
            OP_GT:   r = gt;
            OP_LT:   r = lt;
            default: r = gt | eq;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/serial_magnitude_compare_if.sv
// Request/response bundle for serial_magnitude_compare.
//   request : in_valid, in_ready, in_a, in_b, signed_en, op
//   response: out_valid, out_ready, gt, lt, eq, res
//   status  : busy
// slave is the comparator side, master is the requester/consumer side.
interface serial_magnitude_compare_if
    import serial_magnitude_compare_pkg::*;
#(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             signed_en;
    op_e              op;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             res;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, signed_en, op, out_ready,
        output in_ready, out_valid, gt, lt, eq, res, busy
    );

    modport master (
        output in_valid, in_a, in_b, signed_en, op, out_ready,
        input  in_ready, out_valid, gt, lt, eq, res, busy
    );

endinterface

// File: rtl/serial_magnitude_compare_digit_compare.sv
// digit_compare: combinational unsigned compare of one DIGIT-wide slice.
//   a, b : digit of operand A / B
//   gt   : a > b
//   lt   : a < b   (neither set means the digits are equal)
module digit_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/serial_magnitude_compare.sv
// serial_magnitude_compare: digit-serial, MSB-first magnitude comparator.
// Scans DIGIT bits per cycle from the top, stops at the first differing digit
// and reports gt/lt/eq plus the op-selected result bit.
//   clk : rising-edge clock
//   rst : synchronous, active-low reset
//   bus : serial_magnitude_compare_if.slave (request, response, busy)
// WIDTH must be a multiple of DIGIT.
module serial_magnitude_compare
    import serial_magnitude_compare_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                        clk,
    input logic                        rst,
    serial_magnitude_compare_if.slave  bus
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = idx_width(NDIG);

    state_e                       state;
    op_e                          op_sel;
    logic [IDXW-1:0]              idx;
    logic [NDIG-1:0][DIGIT-1:0]   a_digs;
    logic [NDIG-1:0][DIGIT-1:0]   b_digs;
    logic [WIDTH-1:0]             sign_mask;
    logic                         dig_gt;
    logic                         dig_lt;

    // Inverting the sign bit of both operands maps two's complement order onto
    // plain unsigned order, so the scan itself never needs to know signedness.
    always_comb begin
        sign_mask            = '0;
        sign_mask[WIDTH-1]   = bus.signed_en;
    end

    digit_compare #(.DIGIT(DIGIT)) u_digit (
        .a  (a_digs[idx]),
        .b  (b_digs[idx]),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    assign bus.busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            op_sel        <= OP_EQ;
            idx           <= '0;
            a_digs        <= '0;
            b_digs        <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.gt        <= 1'b0;
            bus.lt        <= 1'b0;
            bus.eq        <= 1'b0;
            bus.res       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        a_digs       <= bus.in_a ^ sign_mask;
                        b_digs       <= bus.in_b ^ sign_mask;
                        op_sel       <= bus.op;
                        idx          <= IDXW'(NDIG - 1);
                        bus.gt       <= 1'b0;
                        bus.lt       <= 1'b0;
                        bus.eq       <= 1'b0;
                        bus.in_ready <= 1'b0;
                        state        <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Flags and res are only written on the way into DONE so they
                    // stay low for as long as out_valid is low.
                    if (dig_gt) begin
                        bus.gt        <= 1'b1;
                        bus.res       <= op_result(op_sel, 1'b1, 1'b0, 1'b0);
                        bus.out_valid <= 1'b1;
                        state         <= ST_DONE;
                    end else if (dig_lt) begin
                        bus.lt        <= 1'b1;
                        bus.res       <= op_result(op_sel, 1'b0, 1'b1, 1'b0);
                        bus.out_valid <= 1'b1;
                        state         <= ST_DONE;
                    end else if (idx == '0) begin
                        bus.eq        <= 1'b1;
                        bus.res       <= op_result(op_sel, 1'b0, 1'b0, 1'b1);
                        bus.out_valid <= 1'b1;
                        state         <= ST_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE costs one bubble: in_ready rises with the
                    // handshake edge, so the next accept is one edge later.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.gt        <= 1'b0;
                        bus.lt        <= 1'b0;
                        bus.eq        <= 1'b0;
                        bus.res       <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    bus.in_ready  <= 1'b0;
                    bus.out_valid <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Directed bench for serial_magnitude_compare: a 16/4 instance and an 8/1
// instance share one set of stimulus variables; sel picks which one is driven.
// Expected results come from an integer reference model and go through a queue.
module tb_serial_magnitude_compare;
    import serial_magnitude_compare_pkg::*;

    typedef struct {
        logic gt;
        logic lt;
        logic eq;
        logic res;
        int   lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        signed_en = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    op_e         op = OP_EQ;

    logic o_ready, o_valid, o_gt, o_lt, o_eq, o_res, o_busy;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_magnitude_compare_if #(.WIDTH(16)) if16 ();
    serial_magnitude_compare_if #(.WIDTH(8))  if8 ();

    assign if16.in_valid  = in_valid & ~sel;
    assign if16.in_a      = in_a;
    assign if16.in_b      = in_b;
    assign if16.signed_en = signed_en;
    assign if16.op        = op;
    assign if16.out_ready = out_ready & ~sel;
    assign if8.in_valid   = in_valid & sel;
    assign if8.in_a       = in_a[7:0];
    assign if8.in_b       = in_b[7:0];
    assign if8.signed_en  = signed_en;
    assign if8.op         = op;
    assign if8.out_ready  = out_ready & sel;

    always_comb begin
        o_ready = sel ? if8.in_ready  : if16.in_ready;
        o_valid = sel ? if8.out_valid : if16.out_valid;
        o_gt    = sel ? if8.gt        : if16.gt;
        o_lt    = sel ? if8.lt        : if16.lt;
        o_eq    = sel ? if8.eq        : if16.eq;
        o_res   = sel ? if8.res       : if16.res;
        o_busy  = sel ? if8.busy      : if16.busy;
    end

    serial_magnitude_compare #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    serial_magnitude_compare #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: integer compare of the w-bit values; latency from the highest
    // differing digit of the raw operands (the sign flip never changes which
    // digits differ).
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input bit s, input op_e o, input int w, input int d);
        exp_t        e;
        logic [15:0] m, ua, ub;
        int          ia, ib, ndig, k;
        bit          found;
        m  = '0;
        for (int i = 0; i < w; i++) m[i] = 1'b1;
        ua = a & m;
        ub = b & m;
        ia = int'(ua);
        ib = int'(ub);
        if (s && ua[w-1]) ia = ia - (1 << w);
        if (s && ub[w-1]) ib = ib - (1 << w);
        e.gt = (ia > ib);
        e.lt = (ia < ib);
        e.eq = (ia == ib);
        case (o)
            OP_EQ:   e.res = e.eq;
            OP_GT:   e.res = e.gt;
            OP_LT:   e.res = e.lt;
            default: e.res = e.gt | e.eq;
        endcase
        ndig  = w / d;
        k     = ndig;
        found = 0;
        for (int i = ndig - 1; i >= 0; i--) begin
            if (!found && ((((ua ^ ub) >> (i * d)) & ((16'h1 << d) - 1)) != 0)) begin
                k     = ndig - i;
                found = 1;
            end
        end
        e.lat = k + 1;
        return e;
    endfunction

    task automatic run(input bit s8, input logic [15:0] a, input logic [15:0] b,
                       input bit s, input op_e o, input int hold, input string tag);
        exp_t e;
        int   n;
        sb.push_back(model(a, b, s, o, s8 ? 8 : 16, s8 ? 1 : 4));
        sel = s8; in_a = a; in_b = b; signed_en = s; op = o; in_valid = 1'b1;
        n = 0;
        while (!o_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_accept_ready"}, o_ready, 1);
        @(posedge clk); #1;                   // accept edge T0
        in_valid = 1'b0;
        in_a = 16'($urandom);
        chk({tag, "_busy_after_accept"}, o_busy, 1);
        n = 0;
        while (!o_valid && n < 40) begin @(posedge clk); #1; n++; end
        e = sb.pop_front();
        chk({tag, "_latency"}, n + 1, e.lat);
        chk({tag, "_gt"}, o_gt, e.gt);
        chk({tag, "_lt"}, o_lt, e.lt);
        chk({tag, "_eq"}, o_eq, e.eq);
        chk({tag, "_res"}, o_res, e.res);
        chk({tag, "_in_ready_done"}, o_ready, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = ~in_valid;
            in_a = 16'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, o_valid, 1);
            chk({tag, "_hold_flags"}, {o_gt, o_lt, o_eq, o_res},
                {e.gt, e.lt, e.eq, e.res});
            chk({tag, "_hold_in_ready"}, o_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, o_valid, 0);
        chk({tag, "_post_flags"}, {o_gt, o_lt, o_eq, o_res}, 0);
        chk({tag, "_post_in_ready"}, o_ready, 1);
        chk({tag, "_post_busy"}, o_busy, 0);
    endtask

    initial begin
        // reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", o_ready, 0);
        chk("rst_out_valid", o_valid, 0);
        chk("rst_flags", {o_gt, o_lt, o_eq, o_res}, 0);
        chk("rst_busy", o_busy, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_in_ready", o_ready, 1);

        run(0, 16'h8000, 16'h7FFF, 0, OP_GT, 0, "u_8000_7fff_gt");
        run(0, 16'h8000, 16'h7FFF, 1, OP_GT, 0, "s_8000_7fff_gt");
        run(0, 16'h1234, 16'h1234, 0, OP_GE, 0, "eq_1234_ge");
        run(0, 16'hFFFB, 16'hFFFC, 1, OP_LT, 0, "s_m5_m4_lt");
        run(0, 16'h0050, 16'h0060, 0, OP_EQ, 0, "u_0050_0060_eq");
        run(0, 16'h0001, 16'hFFFF, 1, OP_GE, 0, "s_1_m1_ge");
        run(0, 16'h00A0, 16'h0090, 0, OP_GT, 3, "hold_00a0_0090");

        // reset mid-SCAN aborts the transaction
        sel = 0; in_a = 16'h1234; in_b = 16'h1234; signed_en = 0; op = OP_EQ;
        in_valid = 1'b1;
        @(posedge clk); #1;                   // accept edge
        in_valid = 1'b0;
        @(posedge clk); #1;                   // one digit scanned
        chk("abort_busy_before", o_busy, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_out_valid", o_valid, 0);
        chk("abort_flags", {o_gt, o_lt, o_eq, o_res}, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_in_ready", o_ready, 0);
        rst = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_no_result", o_valid, 0);
        end
        chk("abort_in_ready_back", o_ready, 1);

        // 8-bit, one bit per cycle
        run(1, 16'h0001, 16'h0000, 0, OP_GT, 0, "w8_01_00_gt");
        run(1, 16'h0080, 16'h007F, 1, OP_LT, 0, "w8_s_80_7f_lt");
        run(1, 16'h005A, 16'h005A, 0, OP_EQ, 1, "w8_5a_eq");

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
